led_matrix_scan: RTL and testbench

// - Consumes the packed 8x24 RGB frame, board[row][23:0], that the display-mapping stage builds.
// - Drives the 8x8 RGB LED matrix through cascaded serial-in shift/latch registers (4 x 8-bit).
// - Scans one row at a time: shifts 32 bits (row select + 24 column bits), latches, then holds.
// - Captures the frame once per scan so the display never tears mid-frame.

---
 rtl/led_matrix_pkg.sv | 36 +++
 rtl/led_matrix_scan_tick_divider.sv | 31 +++
 rtl/led_matrix_scan.sv | 134 +++++++++++++
 tb/tb_led_matrix_scan.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the 8x8 RGB LED matrix scanner.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package led_matrix_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int ROW_BITS    = 24;
    localparam int SR_WORD_W   = 32;

    // One packed frame: [row][23:16 blue, 15:8 green, 7:0 red]
    typedef logic [MATRIX_ROWS-1:0][ROW_BITS-1:0] frame_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        HOLD
    } scan_state_t;

    // Word pushed into the 4-register chain: row select byte first, then columns.
    function automatic logic [SR_WORD_W-1:0] build_word(
        input logic [2:0]          row,
        input logic [ROW_BITS-1:0] cols,
        input logic                col_inv,
        input logic                row_low
    );
        logic [MATRIX_ROWS-1:0] rowsel;
        rowsel = MATRIX_ROWS'(1) << row;
        if (row_low) begin
            rowsel = ~rowsel;
        end
        return {rowsel, cols ^ {ROW_BITS{col_inv}}};
    endfunction

endpackage

// File: rtl/led_matrix_scan_tick_divider.sv
// Shift-tick generator: one-clk tick every DIV clk while not cleared.
// Latency: first tick DIV clk after clr drops.
// Backpressure: none; clr holds the count at zero.
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = !clr && (cnt == LAST);

    // Free-running 0..DIV-1 counter, parked at zero while cleared
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Row scanner: serialises {rowsel, columns} into a 32-bit shift/latch chain, one row at a time.
// Latency: row period = 1 + 65*CLK_DIV + ROW_HOLD clk; st_clk rises 64*CLK_DIV+1 clk after LOAD.
// Backpressure: none; en low lets the current row finish its hold, then parks in IDLE.
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int ROW_HOLD    = 1000,
    parameter bit COL_INVERT  = 1'b1,
    parameter bit ROW_ACT_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  frame_t     board,
    output logic       ds,
    output logic       sh_clk,
    output logic       st_clk,
    output logic       oe_n,
    output logic [2:0] row_idx,
    output logic       frame_done,
    output logic       busy
);

    localparam int                HOLD_W    = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ROW_HOLD - 1);

    scan_state_t           state;
    frame_t                frame_q;
    logic [SR_WORD_W-1:0]  word;
    logic [SR_WORD_W-1:0]  load_word;
    logic [ROW_BITS-1:0]   row_cols;
    logic [5:0]            phase;
    logic [HOLD_W-1:0]     hold_cnt;
    logic                  tick;
    logic                  div_clr;

    // Shift ticks only matter in SHIFT/LATCH; restart the divider on every LOAD
    assign div_clr = (state == IDLE) || (state == LOAD);

    tick_divider #(
        .DIV (CLK_DIV)
    ) u_tick_divider (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (div_clr),
        .tick    (tick)
    );

    // Row 0 reads the live board because frame_q is refreshed on that same edge
    assign row_cols  = (row_idx == 3'd0) ? board[0] : frame_q[row_idx];
    assign load_word = build_word(row_idx, row_cols, COL_INVERT, ROW_ACT_LOW);
    assign busy      = (state != IDLE);

    // Scan FSM: the shifter outputs are registered and set for the phase being entered
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            frame_q    <= '0;
            word       <= '0;
            phase      <= '0;
            hold_cnt   <= '0;
            ds         <= 1'b0;
            sh_clk     <= 1'b0;
            st_clk     <= 1'b0;
            oe_n       <= 1'b1;
            row_idx    <= 3'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (row_idx == 3'd0) begin
                        frame_q <= board;
                    end
                    // Present bit 31 now; word keeps only the bits still to go
                    ds     <= load_word[SR_WORD_W-1];
                    sh_clk <= 1'b0;
                    word   <= load_word << 1;
                    phase  <= 6'd0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        phase <= phase + 6'd1;
                        if (!phase[0]) begin
                            sh_clk <= 1'b1;
                        end else if (phase == 6'd63) begin
                            sh_clk <= 1'b0;
                            st_clk <= 1'b1;
                            oe_n   <= 1'b1;
                            state  <= LATCH;
                        end else begin
                            sh_clk <= 1'b0;
                            ds     <= word[SR_WORD_W-1];
                            word   <= word << 1;
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        st_clk   <= 1'b0;
                        oe_n     <= 1'b0;
                        hold_cnt <= '0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        row_idx    <= row_idx + 3'd1;
                        frame_done <= (row_idx == 3'd7);
                        if (en) begin
                            state <= LOAD;
                        end else begin
                            oe_n  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: two instances (plain polarity / inverted polarity, divided tick).
// Outputs are sampled just after the falling edge; words are rebuilt from ds on sh_clk rises.
// Expected words and timings come from a row/frame model of the scan rules.
module tb_led_matrix_scan;
    import led_matrix_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       en_a, en_b;
    frame_t     board_a, board_b;
    logic       ds_a, sh_a, st_a, oe_a, fd_a, busy_a;
    logic       ds_b, sh_b, st_b, oe_b, fd_b, busy_b;
    logic [2:0] row_a, row_b;

    led_matrix_scan #(.CLK_DIV(1), .ROW_HOLD(4), .COL_INVERT(1'b0), .ROW_ACT_LOW(1'b0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .en(en_a), .board(board_a),
        .ds(ds_a), .sh_clk(sh_a), .st_clk(st_a), .oe_n(oe_a),
        .row_idx(row_a), .frame_done(fd_a), .busy(busy_a)
    );

    led_matrix_scan #(.CLK_DIV(2), .ROW_HOLD(3), .COL_INVERT(1'b1), .ROW_ACT_LOW(1'b1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .en(en_b), .board(board_b),
        .ds(ds_b), .sh_clk(sh_b), .st_clk(st_b), .oe_n(oe_b),
        .row_idx(row_b), .frame_done(fd_b), .busy(busy_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Observed events
    logic [31:0] acc_a = '0, acc_b = '0;
    int          nb_a = 0, nb_b = 0;
    logic        sh_a_p = 0, st_a_p = 0, busy_a_p = 0;
    logic        sh_b_p = 0, st_b_p = 0, busy_b_p = 0;
    logic [31:0] lw_a[$], lw_b[$];
    int          lr_a[$], lr_b[$], lc_a[$], lc_b[$], lnb_a[$], lnb_b[$];
    int          bs_a[$], bs_b[$], fd_q[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset_n) begin
            acc_a = '0; nb_a = 0; acc_b = '0; nb_b = 0;
        end else begin
            if (sh_a && !sh_a_p) begin acc_a = {acc_a[30:0], ds_a}; nb_a++; end
            if (st_a && !st_a_p) begin
                lw_a.push_back(acc_a); lr_a.push_back(int'(row_a));
                lc_a.push_back(cyc); lnb_a.push_back(nb_a); nb_a = 0;
            end
            if (fd_a) fd_q.push_back(cyc);
            if (busy_a && !busy_a_p) bs_a.push_back(cyc);
            if (sh_b && !sh_b_p) begin acc_b = {acc_b[30:0], ds_b}; nb_b++; end
            if (st_b && !st_b_p) begin
                lw_b.push_back(acc_b); lr_b.push_back(int'(row_b));
                lc_b.push_back(cyc); lnb_b.push_back(nb_b); nb_b = 0;
            end
            if (busy_b && !busy_b_p) bs_b.push_back(cyc);
        end
        sh_a_p = sh_a; st_a_p = st_a; busy_a_p = busy_a;
        sh_b_p = sh_b; st_b_p = st_b; busy_b_p = busy_b;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: row select is one-hot (or one-cold), columns optionally inverted
    function automatic logic [31:0] exp_word(input frame_t f, input int r, input bit ci, input bit ra);
        logic [7:0]  sel;
        logic [23:0] col;
        for (int k = 0; k < 8; k++) sel[k] = ra ? (k != r) : (k == r);
        col = ci ? ~f[r] : f[r];
        return {sel, col};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    function automatic int qsize(input int which);
        case (which)
            0: return lc_a.size();
            1: return bs_a.size();
            2: return lc_b.size();
            default: return bs_b.size();
        endcase
    endfunction

    // Bounded wait for an event count; a timeout is fatal since later reads need the entries
    task automatic wait_q(input int which, input int n, input int budget, input string tag);
        int b;
        b = budget;
        while (qsize(which) < n && b > 0) begin step(); b--; end
        chk(tag, qsize(which), n);
        if (qsize(which) < n) begin
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $fatal(1, "FAIL timeout %s", tag);
        end
    endtask

    task automatic clear_a();
        lw_a.delete(); lr_a.delete(); lc_a.delete(); lnb_a.delete(); bs_a.delete(); fd_q.delete();
    endtask

    task automatic clear_b();
        lw_b.delete(); lr_b.delete(); lc_b.delete(); lnb_b.delete(); bs_b.delete();
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (busy_a && n < 100) begin step(); n++; end
    endtask

    frame_t snaps[4];
    int     s, r0, sb, n, row, fr, at;

    initial begin
        reset_n = 1'b0; en_a = 1'b0; en_b = 1'b0; board_a = '0; board_b = '0;
        repeat (3) step();
        chk("rst_ds", ds_a, 0);      chk("rst_sh_clk", sh_a, 0); chk("rst_st_clk", st_a, 0);
        chk("rst_oe_n", oe_a, 1);    chk("rst_busy", busy_a, 0); chk("rst_row", row_a, 0);
        chk("rst_fd", fd_a, 0);      chk("rst_b_busy", busy_b, 0); chk("rst_b_oe_n", oe_b, 1);
        reset_n = 1'b1;
        repeat (5) step();
        chk("idle_busy", busy_a, 0);
        chk("idle_oe_n", oe_a, 1);

        // Single row, en dropped mid-shift so the row ends in IDLE
        for (int r = 0; r < 8; r++) board_a[r] = 24'($urandom);
        board_a[0] = 24'hFF0001;
        clear_a();
        en_a = 1'b1;
        wait_q(1, 1, 20, "row_start");
        s = bs_a[0];
        wait_cyc(s + 10);
        en_a = 1'b0;
        wait_q(0, 1, 200, "row_latch");
        chk("row_word", lw_a[0], 32'h01FF0001);
        chk("row_bits", lnb_a[0], 32);
        chk("row_st_after_load", lc_a[0] - s, 65);
        chk("row_oe_before_hold", oe_a, 1);
        step();
        chk("row_st_one_tick", st_a, 0);
        n = 0;
        while (oe_a == 1'b0 && n < 20) begin n++; step(); end
        chk("row_oe_low_clk", n, 4);
        chk("row_end_busy", busy_a, 0);
        chk("row_end_idx", row_a, 1);
        chk("row_no_fd", fd_q.size(), 0);

        // Full frames, snapshot, enable drop and resume
        reset_n = 1'b0; step(); reset_n = 1'b1;
        clear_a();
        for (int r = 0; r < 8; r++) board_a[r] = 24'h000001 << r;
        snaps[0] = board_a;
        en_a = 1'b1;
        wait_q(1, 1, 20, "frm_start");
        s = bs_a[0];
        wait_cyc(s + 2 * 70 + 20);
        board_a[5] = snaps[0][5] ^ (24'($urandom) | 24'h1);
        snaps[1] = board_a;
        snaps[2] = board_a;
        wait_cyc(s + 19 * 70 + 10);
        en_a = 1'b0;
        wait_q(0, 20, 400, "drop_latches");
        wait_idle_a();
        chk("drop_busy", busy_a, 0);
        chk("drop_oe_n", oe_a, 1);
        chk("drop_row", row_a, 4);
        board_a[4] = snaps[2][4] ^ (24'($urandom) | 24'h1);
        board_a[0] = snaps[2][0] ^ (24'($urandom) | 24'h1);
        snaps[3] = board_a;
        repeat (7) step();
        chk("idle_stays", busy_a, 0);
        en_a = 1'b1;
        wait_q(1, 2, 20, "resume_start");
        r0 = bs_a[1];
        wait_cyc(r0 + 280 + 20);
        en_a = 1'b0;
        wait_q(0, 25, 400, "resume_latches");
        wait_idle_a();
        for (int i = 0; i < 25; i++) begin
            row = (i < 20) ? (i % 8) : ((i - 20 + 4) % 8);
            fr  = (i < 20) ? (i / 8) : ((i < 24) ? 2 : 3);
            at  = (i < 20) ? (s + 65 + 70 * i) : (r0 + 65 + 70 * (i - 20));
            chk($sformatf("frm_word%0d", i), lw_a[i], exp_word(snaps[fr], row, 1'b0, 1'b0));
            chk($sformatf("frm_row%0d", i), lr_a[i], row);
            chk($sformatf("frm_cyc%0d", i), lc_a[i], at);
            chk($sformatf("frm_bits%0d", i), lnb_a[i], 32);
        end
        chk("fd_count", fd_q.size(), 3);
        if (fd_q.size() == 3) begin
            chk("fd0_at", fd_q[0] - s, 560);
            chk("fd1_at", fd_q[1] - s, 1120);
            chk("fd2_at", fd_q[2] - r0, 280);
        end

        // Inverted polarity, divided tick, then reset in the middle of a shift
        clear_b();
        for (int r = 1; r < 8; r++) board_b[r] = 24'($urandom);
        board_b[0] = 24'h000000;
        en_b = 1'b1;
        wait_q(3, 1, 20, "pol_start");
        sb = bs_b[0];
        wait_q(2, 8, 8 * 134 + 200, "pol_latches");
        chk("pol_word0", lw_b[0], 32'hFEFFFFFF);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pol_word%0d", i), lw_b[i], exp_word(board_b, i, 1'b1, 1'b1));
            chk($sformatf("pol_row%0d", i), lr_b[i], i);
            chk($sformatf("pol_cyc%0d", i), lc_b[i], sb + 129 + 134 * i);
        end
        wait_cyc(sb + 9 * 134 + 40);
        chk("pre_rst_row", row_b, 1);
        chk("pre_rst_busy", busy_b, 1);
        reset_n = 1'b0;
        step();
        chk("mid_rst_ds", ds_b, 0);     chk("mid_rst_sh_clk", sh_b, 0); chk("mid_rst_st_clk", st_b, 0);
        chk("mid_rst_oe_n", oe_b, 1);   chk("mid_rst_row", row_b, 0);   chk("mid_rst_fd", fd_b, 0);
        chk("mid_rst_busy", busy_b, 0);
        board_b[0] = 24'($urandom) | 24'h1;
        clear_b();
        reset_n = 1'b1;
        wait_q(3, 1, 20, "post_rst_start");
        sb = bs_b[0];
        wait_q(2, 1, 300, "post_rst_latch");
        chk("post_rst_row", lr_b[0], 0);
        chk("post_rst_word", lw_b[0], exp_word(board_b, 0, 1'b1, 1'b1));
        chk("post_rst_cyc", lc_b[0] - sb, 129);
        en_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
